keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 255 +++++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// ----------------------------------------------------------------------------
// keypad_scan
//   Scans a 4x4 matrix keypad one column at a time and debounces a single key.
//   A key is accepted only after DEB_CNT consecutive matching samples. It is
//   released only after DEB_CNT consecutive all-high samples. Each sample is
//   taken once per SCAN_DIV-cycle column dwell.
//
// Parameters
//   SCAN_DIV : clk cycles per column dwell (4 .. 2^20)
//   DEB_CNT  : consecutive matching samples to accept a press/release (2 .. 255)
//
// Ports
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active low
//   row  : keypad rows (pulled up, low = closed), asynchronous to clk
//   col  : column drive, exactly one bit low
//   key  : hex code of the last accepted key
//   flag : high while the accepted key is held (debounced)
// ----------------------------------------------------------------------------
module keypad_scan #(
    parameter int SCAN_DIV = 100000,
    parameter int DEB_CNT  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       flag
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [8:0]      DEB_LAST = 9'(DEB_CNT);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t r_state;
    state_t w_state_n;

    logic [3:0]       r_row_m;
    logic [3:0]       r_row_s;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_col;
    logic [3:0]       r_lat_row;
    logic [3:0]       r_key;
    logic             r_flag;
    logic [7:0]       r_match_cnt;
    logic [7:0]       r_rel_cnt;

    logic       w_sample;
    logic       w_row_one_low;
    logic       w_row_idle;
    logic       w_row_match;
    logic [8:0] w_match_sum;
    logic [8:0] w_rel_sum;
    logic       w_match_done;
    logic       w_rel_done;

    // FSM strobes (Mealy, qualified by the sample point)
    logic w_latch;
    logic w_col_rotate;
    logic w_match_inc;
    logic w_match_clr;
    logic w_key_load;
    logic w_flag_set;
    logic w_flag_clr;
    logic w_rel_start;
    logic w_rel_inc;
    logic w_rel_clr;

    // Position of the single low bit; callers only use it on one-low patterns
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    assign w_sample      = (r_div == DIV_LAST);
    assign w_row_one_low = (r_row_s == 4'b1110) || (r_row_s == 4'b1101) ||
                           (r_row_s == 4'b1011) || (r_row_s == 4'b0111);
    assign w_row_idle    = (r_row_s == 4'b1111);
    assign w_row_match   = (r_row_s == r_lat_row);

    // 9-bit sums so the saturation compare cannot wrap at DEB_CNT = 255
    assign w_match_sum  = {1'b0, r_match_cnt} + 9'd1;
    assign w_rel_sum    = {1'b0, r_rel_cnt} + 9'd1;
    assign w_match_done = (w_match_sum >= DEB_LAST);
    assign w_rel_done   = (w_rel_sum >= DEB_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_SCAN;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_n = r_state;
        if (w_sample) begin
            case (r_state)
                S_SCAN: begin
                    if (w_row_one_low) w_state_n = S_DEBOUNCE;
                end
                S_DEBOUNCE: begin
                    if (!w_row_match)      w_state_n = S_SCAN;
                    else if (w_match_done) w_state_n = S_HOLD;
                end
                S_HOLD: begin
                    if (w_row_idle) w_state_n = S_RELEASE;
                end
                S_RELEASE: begin
                    if (!w_row_idle)     w_state_n = S_HOLD;
                    else if (w_rel_done) w_state_n = S_SCAN;
                end
                default: w_state_n = S_SCAN;
            endcase
        end
    end

    // Output / datapath control logic
    always_comb begin
        w_latch      = 1'b0;
        w_col_rotate = 1'b0;
        w_match_inc  = 1'b0;
        w_match_clr  = 1'b0;
        w_key_load   = 1'b0;
        w_flag_set   = 1'b0;
        w_flag_clr   = 1'b0;
        w_rel_start  = 1'b0;
        w_rel_inc    = 1'b0;
        w_rel_clr    = 1'b0;
        if (w_sample) begin
            case (r_state)
                S_SCAN: begin
                    if (w_row_one_low) w_latch      = 1'b1;
                    else               w_col_rotate = 1'b1;
                end
                S_DEBOUNCE: begin
                    if (w_row_match) begin
                        w_match_inc = 1'b1;
                        if (w_match_done) begin
                            w_key_load = 1'b1;
                            w_flag_set = 1'b1;
                        end
                    end else begin
                        w_match_clr  = 1'b1;
                        w_col_rotate = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_row_idle) w_rel_start = 1'b1;
                end
                S_RELEASE: begin
                    if (w_row_idle) begin
                        w_rel_inc = 1'b1;
                        if (w_rel_done) begin
                            w_flag_clr   = 1'b1;
                            w_col_rotate = 1'b1;
                        end
                    end else begin
                        w_rel_clr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Synchronizer, divider, column drive, counters and outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_row_m     <= '1;
            r_row_s     <= '1;
            r_div       <= '0;
            r_col       <= 4'b1110;
            r_lat_row   <= '1;
            r_key       <= '0;
            r_flag      <= 1'b0;
            r_match_cnt <= '0;
            r_rel_cnt   <= '0;
        end else begin
            r_row_m <= row;
            r_row_s <= r_row_m;
            r_div   <= w_sample ? '0 : r_div + DIV_W'(1);

            if (w_col_rotate) r_col <= {r_col[2:0], r_col[3]};

            if (w_latch) begin
                r_lat_row   <= r_row_s;
                r_match_cnt <= 8'd1;
            end else if (w_match_clr) begin
                r_match_cnt <= '0;
            end else if (w_match_inc) begin
                r_match_cnt <= w_match_done ? DEB_LAST[7:0] : w_match_sum[7:0];
            end

            if (w_rel_start) begin
                r_rel_cnt <= 8'd1;
            end else if (w_rel_clr) begin
                r_rel_cnt <= '0;
            end else if (w_rel_inc) begin
                r_rel_cnt <= w_rel_done ? DEB_LAST[7:0] : w_rel_sum[7:0];
            end

            // col is frozen through DEBOUNCE, so it still holds the latched column
            if (w_key_load) r_key <= key_code(low_index(r_lat_row), low_index(r_col));

            if (w_flag_set)      r_flag <= 1'b1;
            else if (w_flag_clr) r_flag <= 1'b0;
        end
    end

    assign col  = r_col;
    assign key  = r_key;
    assign flag = r_flag;

endmodule

// File: tb/tb_keypad_scan.sv
// ----------------------------------------------------------------------------
// tb_keypad_scan
//   Directed bench for keypad_scan with SCAN_DIV=4, DEB_CNT=3. Row patterns
//   are driven just after a sample edge so they are visible through the
//   synchronizer at the next sample point; checks are made 1 time unit after
//   sample edges.
// ----------------------------------------------------------------------------
module tb_keypad_scan;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       flag;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    keypad_scan #(
        .SCAN_DIV(4),
        .DEB_CNT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .row (row),
        .col (col),
        .key (key),
        .flag(flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance n sample points (4 clocks each) and settle past the edge
    task automatic samples(input int unsigned n);
        repeat (n * 4) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        row = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col",  col,  4'b1110);
        check("rst_key",  key,  4'h0);
        check("rst_flag", {3'b000, flag}, 4'h0);

        // Two rows low never counts as a key; rotation continues
        rst = 1'b1;
        row = 4'b1100;
        repeat (3) @(posedge clk);
        #1;
        check("first_dwell_col", col, 4'b1110);
        @(posedge clk);
        #1;
        check("s1_col",  col, 4'b1101);
        check("s1_flag", {3'b000, flag}, 4'h0);
        samples(1);
        check("s2_col",  col, 4'b1011);
        samples(2);
        check("s4_col",  col, 4'b1110);
        check("s4_flag", {3'b000, flag}, 4'h0);

        // Star key: row 3 on column 0, three presses then three releases
        row = 4'b0111;
        samples(1);
        check("star_latch_col", col, 4'b1110);
        check("star_latch_flag", {3'b000, flag}, 4'h0);
        samples(1);
        check("star_m2_flag", {3'b000, flag}, 4'h0);
        samples(1);
        check("star_flag", {3'b000, flag}, 4'h1);
        check("star_key",  key, 4'hE);
        check("star_col",  col, 4'b1110);
        row = 4'hF;
        samples(2);
        check("star_rel2_flag", {3'b000, flag}, 4'h1);
        samples(1);
        check("star_rel3_flag", {3'b000, flag}, 4'h0);
        check("star_rel3_col",  col, 4'b1101);
        check("star_rel3_key",  key, 4'hE);

        // Row 1 on column 2 -> key 6 from the key map; long hold
        samples(1);
        check("s11_col", col, 4'b1011);
        row = 4'b1101;
        samples(2);
        check("k6_m2_flag", {3'b000, flag}, 4'h0);
        samples(1);
        check("k6_flag", {3'b000, flag}, 4'h1);
        check("k6_key",  key, 4'h6);
        for (int i = 0; i < 8; i++) begin
            samples(1);
            check("k6_hold_flag", {3'b000, flag}, 4'h1);
            check("k6_hold_col",  col, 4'b1011);
        end
        // Release glitch: two idle samples then the key reappears
        row = 4'hF;
        samples(2);
        check("glitch_rel_flag", {3'b000, flag}, 4'h1);
        row = 4'b1101;
        samples(1);
        check("glitch_back_flag", {3'b000, flag}, 4'h1);
        // A different key while held is ignored
        row = 4'b1110;
        samples(1);
        check("second_key_key",  key, 4'h6);
        check("second_key_flag", {3'b000, flag}, 4'h1);
        check("second_key_col",  col, 4'b1011);
        row = 4'hF;
        samples(2);
        check("k6_rel2_flag", {3'b000, flag}, 4'h1);
        samples(1);
        check("k6_rel3_flag", {3'b000, flag}, 4'h0);
        check("k6_rel3_col",  col, 4'b0111);
        check("k6_rel3_key",  key, 4'h6);

        // Bounce: one matching sample then a mismatch returns to scanning
        row = 4'b1110;
        samples(1);
        check("bounce_latch_col",  col, 4'b0111);
        check("bounce_latch_flag", {3'b000, flag}, 4'h0);
        row = 4'hF;
        samples(1);
        check("bounce_col",  col, 4'b1110);
        check("bounce_flag", {3'b000, flag}, 4'h0);
        check("bounce_key",  key, 4'h6);
        samples(1);
        check("bounce_next_col",  col, 4'b1101);
        check("bounce_next_flag", {3'b000, flag}, 4'h0);

        // Row 0 on column 1 -> key 2, then reset while flag is high
        row = 4'b1110;
        samples(3);
        check("k2_flag", {3'b000, flag}, 4'h1);
        check("k2_key",  key, 4'h2);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_flag", {3'b000, flag}, 4'h0);
        check("midrst_key",  key, 4'h0);
        check("midrst_col",  col, 4'b1110);

        // Key still down: a full fresh debounce is needed (row 0, column 0 -> 1)
        rst = 1'b1;
        samples(2);
        check("post_rst_m2_flag", {3'b000, flag}, 4'h0);
        samples(1);
        check("post_rst_flag", {3'b000, flag}, 4'h1);
        check("post_rst_key",  key, 4'h1);
        check("post_rst_col",  col, 4'b1110);
        row = 4'hF;
        samples(3);
        check("post_rst_rel_flag", {3'b000, flag}, 4'h0);
        check("post_rst_rel_col",  col, 4'b1101);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
